// File: rtl/fwrisc_mem_pkg.sv
// fwrisc_mem_pkg: shared types and constants for the FWRISC memory arbiter.
//   arb_state_t : transaction FSM states (IDLE -> CMD -> RESP -> IDLE)
//   MEM_REGION  : value of addr[31:28] that selects the on-chip memory
package fwrisc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic [3:0] MEM_REGION = 4'h8;

endpackage

// File: rtl/fwrisc_mem_arb_sel.sv
// fwrisc_mem_arb_sel: grant selection between instruction and data ports.
// Data wins by default; an instruction request that has watched MAX_DSTREAK
// data grants in a row wins the next arbitration.
//   clock, reset     : clock, async active-low reset
//   sample           : arbitration allowed this cycle (FSM idle)
//   ivalid, dvalid   : port requests
//   grant_i, grant_d : one-hot grant, only while sample is high
module fwrisc_mem_arb_sel #(
  parameter int MAX_DSTREAK = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic sample,
  input  logic ivalid,
  input  logic dvalid,
  output logic grant_i,
  output logic grant_d
);

  localparam int SW = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  logic [SW-1:0] dstreak;
  logic          starved;

  assign starved = ivalid && (dstreak == STREAK_MAX);
  assign grant_d = sample && dvalid && !starved;
  assign grant_i = sample && ivalid && !grant_d;

  // Only data grants that actually kept an instruction waiting count
  // toward the streak.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dstreak <= '0;
    end else if (grant_i) begin
      dstreak <= '0;
    end else if (grant_d) begin
      if (!ivalid)
        dstreak <= '0;
      else if (dstreak != STREAK_MAX)
        dstreak <= dstreak + 1'b1;
    end
  end

endmodule

// File: rtl/fwrisc_mem_arb.sv
// fwrisc_mem_arb: shares one single-port synchronous memory between the
// FWRISC instruction-fetch and data ports. One transaction every 3 cycles:
// IDLE (grant + latch request), CMD (memory strobe), RESP (ready pulse).
//   clock, reset                         : clock, async active-low reset
//   iaddr, ivalid / iready, idata        : instruction fetch port
//   daddr, dwdata, dstrb, dwrite, dvalid : data request port
//   dready, drdata                       : data response
//   maddr, mvalid, mwrite, mstrb, mwdata : memory command
//   mrdata                               : memory read data (1-cycle latency)
module fwrisc_mem_arb
  import fwrisc_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 11,
  parameter int MAX_DSTREAK = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           iaddr,
  input  logic                  ivalid,
  output logic                  iready,
  output logic [31:0]           idata,
  input  logic [31:0]           daddr,
  input  logic [31:0]           dwdata,
  input  logic [3:0]            dstrb,
  input  logic                  dwrite,
  input  logic                  dvalid,
  output logic                  dready,
  output logic [31:0]           drdata,
  output logic [ADDR_WIDTH-1:0] maddr,
  output logic                  mvalid,
  output logic                  mwrite,
  output logic [3:0]            mstrb,
  output logic [31:0]           mwdata,
  input  logic [31:0]           mrdata
);

  arb_state_t state, state_nxt;

  logic                  grant_i, grant_d, in_idle;
  logic [31:0]           req_addr;
  logic                  unused_req_addr;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  hit_q, data_q, write_q;
  logic [3:0]            strb_q;
  logic [31:0]           wdata_q, idata_q, drdata_q, rd_word;

  assign in_idle = (state == IDLE);

  fwrisc_mem_arb_sel #(
    .MAX_DSTREAK(MAX_DSTREAK)
  ) u_sel (
    .clock   (clock),
    .reset   (reset),
    .sample  (in_idle),
    .ivalid  (ivalid),
    .dvalid  (dvalid),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  assign req_addr = grant_d ? daddr : iaddr;
  // Byte offset and bits between the word index and the region nibble
  // play no part in the access.
  assign unused_req_addr = ^{req_addr[27:ADDR_WIDTH+2], req_addr[1:0]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mvalid    = 1'b0;
    mwrite    = 1'b0;
    mstrb     = 4'h0;
    iready    = 1'b0;
    dready    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_i || grant_d) state_nxt = CMD;
      end
      CMD: begin
        state_nxt = RESP;
        // Out-of-region accesses never reach the memory.
        mvalid = hit_q;
        mwrite = hit_q && write_q;
        mstrb  = (hit_q && write_q) ? strb_q : 4'h0;
      end
      RESP: begin
        state_nxt = IDLE;
        iready    = !data_q;
        dready    = data_q;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_word = hit_q ? mrdata : 32'h0;
  assign maddr   = addr_q;
  assign mwdata  = wdata_q;
  // Read data is forwarded during the ready cycle and held afterwards.
  assign idata   = iready ? rd_word : idata_q;
  assign drdata  = (dready && !write_q) ? rd_word : drdata_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q   <= '0;
      hit_q    <= 1'b0;
      data_q   <= 1'b0;
      write_q  <= 1'b0;
      strb_q   <= 4'h0;
      wdata_q  <= 32'h0;
      idata_q  <= 32'h0;
      drdata_q <= 32'h0;
    end else begin
      if (grant_i || grant_d) begin
        addr_q  <= req_addr[ADDR_WIDTH+1:2];
        hit_q   <= (req_addr[31:28] == MEM_REGION);
        data_q  <= grant_d;
        write_q <= grant_d && dwrite;
        strb_q  <= grant_d ? dstrb : 4'h0;
        if (grant_d) wdata_q <= dwdata;
      end
      if (iready) idata_q <= rd_word;
      if (dready && !write_q) drdata_q <= rd_word;
    end
  end

endmodule
